// File: rtl/ex_divider_if.sv
// ex_divider_if: start/operand and result bundle for the EX-stage divider.
// The pipeline side drives operands; the divider returns busy/done/divres.
interface ex_divider_if;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        hold;
  logic        busy;
  logic        done;
  logic [63:0] divres;

  modport master (
    output start,
    output signed_op,
    output dividend,
    output divisor,
    output cancel,
    output hold,
    input  busy,
    input  done,
    input  divres
  );

  modport slave (
    input  start,
    input  signed_op,
    input  dividend,
    input  divisor,
    input  cancel,
    input  hold,
    output busy,
    output done,
    output divres
  );
endinterface

// File: rtl/ex_divider.sv
// ex_divider: radix-2 restoring DIV/DIVU for the EX stage.
// Result packs {remainder, quotient}; one quotient bit per cycle.
module ex_divider (
  input  logic         clk,
  input  logic         rst,
  ex_divider_if.slave  dif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] dvd_q;
  logic [31:0] dvs_q;
  logic [32:0] rem_q;
  logic        negq_q;
  logic        negr_q;
  logic [63:0] divres_q;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        accept;
  logic [33:0] shift_d;
  logic [33:0] trial_d;
  logic        qbit_d;
  logic [32:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign a_neg = dif.signed_op & dif.dividend[31];
  assign b_neg = dif.signed_op & dif.divisor[31];
  assign a_mag = a_neg ? (~dif.dividend + 32'd1) : dif.dividend;
  assign b_mag = b_neg ? (~dif.divisor + 32'd1) : dif.divisor;

  assign accept = (state_q == IDLE) & dif.start & ~dif.cancel;

  // Partial remainder stays below the divisor, so the 34-bit
  // difference's top bit is a clean borrow flag.
  assign shift_d = {rem_q, dvd_q[31]};
  assign trial_d = shift_d - {2'b00, dvs_q};
  assign qbit_d  = ~trial_d[33];
  assign rem_d   = qbit_d ? trial_d[32:0] : shift_d[32:0];
  assign quo_d   = {dvd_q[30:0], qbit_d};

  assign quo_fix = negq_q ? (~quo_d + 32'd1) : quo_d;
  assign rem_fix = negr_q ? (~rem_d[31:0] + 32'd1) : rem_d[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 33'd0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      divres_q <= 64'd0;
    end else if (dif.cancel) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (dif.start) begin
            dvd_q  <= a_mag;
            dvs_q  <= b_mag;
            rem_q  <= 33'd0;
            cnt_q  <= 6'd0;
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
            if (dif.divisor == 32'd0) begin
              divres_q <= {dif.dividend, 32'hFFFF_FFFF};
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            divres_q <= {rem_fix, quo_fix};
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (!dif.hold) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dif.busy   = ~rst & ((state_q == CALC) | accept);
  assign dif.done   = (state_q == DONE);
  assign dif.divres = divres_q;

endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: vector table plus hand sequences for cancel,
// hold, divide-by-zero and reset corners of ex_divider.
module tb_ex_divider;

  logic clk;
  logic rst;
  ex_divider_if dif ();

  ex_divider dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t v[11];
  int total;
  int bad;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a,
                     input logic [31:0] b, output int lat,
                     output int nbusy, output logic [63:0] res);
    @(posedge clk); #1;
    dif.start     = 1'b1;
    dif.signed_op = s;
    dif.dividend  = a;
    dif.divisor   = b;
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    if (dif.busy) nbusy++;
    while (!dif.done && lat < 40) begin
      @(posedge clk); #1;
      dif.start = 1'b0;
      lat++;
      @(negedge clk);
      if (dif.busy) nbusy++;
    end
    res = dif.divres;
  endtask

  int lat;
  int nb;
  int n;
  logic [63:0] res;

  initial begin
    total = 0;
    bad   = 0;

    v[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 33};
    v[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33};
    v[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  {32'h0000_0002, 32'hFFFF_FFF2}, 33};
    v[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000}, 33};
    v[4]  = '{1'b0, 32'h1234_5678,  32'h0,          {32'h1234_5678, 32'hFFFF_FFFF}, 1};
    v[5]  = '{1'b1, 32'hFFFF_FF9C,  32'h0,          {32'hFFFF_FF9C, 32'hFFFF_FFFF}, 1};
    v[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0, 32'hFFFF_FFFF}, 33};
    v[7]  = '{1'b0, 32'd7,          32'd100,        {32'd7, 32'd0}, 33};
    v[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3}, 33};
    v[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0, 32'd1}, 33};
    v[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0}, 33};

    rst           = 1'b1;
    dif.start     = 1'b1;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'd5;
    dif.divisor   = 32'd1;
    dif.cancel    = 1'b0;
    dif.hold      = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(dif.busy), 64'd0);
    @(negedge clk);
    chk("rst_done", 64'(dif.done), 64'd0);
    chk("rst_divres", dif.divres, 64'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    dif.start = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run(v[i].s, v[i].a, v[i].b, lat, nb, res);
      chk($sformatf("vec%0d_res", i), res, v[i].r);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(v[i].lat));
      chk($sformatf("vec%0d_busy", i), 64'(nb), 64'(v[i].lat));
    end

    // cancel together with start: not accepted
    @(posedge clk); #1;
    dif.start    = 1'b1;
    dif.cancel   = 1'b1;
    dif.dividend = 32'd20;
    dif.divisor  = 32'd4;
    @(negedge clk);
    chk("cstart_busy", 64'(dif.busy), 64'd0);
    @(posedge clk); #1;
    dif.start  = 1'b0;
    dif.cancel = 1'b0;
    @(negedge clk);
    chk("cstart_busy2", 64'(dif.busy), 64'd0);
    chk("cstart_done", 64'(dif.done), 64'd0);

    // cancel at iteration 10
    @(posedge clk); #1;
    dif.start     = 1'b1;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'd1000;
    dif.divisor   = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      dif.start = 1'b0;
    end
    dif.cancel = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    dif.cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 64'(dif.busy), 64'd0);
    chk("cancel_done", 64'(dif.done), 64'd0);
    chk("cancel_keep", dif.divres, {32'h8000_0000, 32'h0});
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.done || dif.busy) n++;
    end
    chk("cancel_quiet", 64'(n), 64'd0);
    run(1'b0, 32'd9, 32'd3, lat, nb, res);
    chk("after_cancel_res", res, {32'd0, 32'd3});
    chk("after_cancel_lat", 64'(lat), 64'd33);

    // hold in DONE with start still high
    @(posedge clk); #1;
    dif.hold      = 1'b1;
    dif.start     = 1'b1;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'd50;
    dif.divisor   = 32'd5;
    n = 0;
    @(negedge clk);
    while (!dif.done && n < 40) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
    end
    chk("hold_lat", 64'(n), 64'd33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("hold%0d_done", i), 64'(dif.done), 64'd1);
      chk($sformatf("hold%0d_res", i), dif.divres, {32'd0, 32'd10});
      chk($sformatf("hold%0d_busy", i), 64'(dif.busy), 64'd0);
    end
    @(posedge clk); #1;
    dif.hold  = 1'b0;
    dif.start = 1'b0;
    @(negedge clk);
    chk("hold_rel_done", 64'(dif.done), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_idle_done", 64'(dif.done), 64'd0);
    chk("hold_idle_busy", 64'(dif.busy), 64'd0);

    // reset mid-CALC
    @(posedge clk); #1;
    dif.start    = 1'b1;
    dif.dividend = 32'd1000;
    dif.divisor  = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      dif.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy_comb", 64'(dif.busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_done", 64'(dif.done), 64'd0);
    chk("mrst_busy", 64'(dif.busy), 64'd0);
    chk("mrst_divres", dif.divres, 64'd0);
    run(1'b1, 32'hFFFF_FF9C, 32'd7, lat, nb, res);
    chk("mrst_next_res", res, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
